// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad conditioner: button indices within a
// joystick, channels per player, and the default auto-repeat eligibility mask.
// Auto-repeat itself is selected by the GAMEPAD_AUTOREPEAT_EN macro in the
// files that import this package.
package gamepad_pkg;

    localparam int BTN_UP          = 0;
    localparam int BTN_DOWN        = 1;
    localparam int BTN_LEFT        = 2;
    localparam int BTN_RIGHT       = 3;
    localparam int BTN_FIRE        = 4;
    localparam int BTNS_PER_PLAYER = 5;

    // Upper bound on joysticks the default mask helper can describe.
    localparam int MAX_PLAYERS  = 32;
    localparam int MAX_CHANNELS = BTNS_PER_PLAYER * MAX_PLAYERS;

    // Directions repeat when held; fire never does, so a held trigger
    // cannot spray shots.
    function automatic logic [MAX_CHANNELS-1:0] default_repeat_mask(input int num_players);
        logic [MAX_CHANNELS-1:0] mask;
        int base;
        mask = '0;
        for (int p = 0; p < num_players && p < MAX_PLAYERS; p++) begin
            base = p * BTNS_PER_PLAYER;
            mask[base + BTN_UP]    = 1'b1;
            mask[base + BTN_DOWN]  = 1'b1;
            mask[base + BTN_LEFT]  = 1'b1;
            mask[base + BTN_RIGHT] = 1'b1;
            mask[base + BTN_FIRE]  = 1'b0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/gamepad_channel.sv
// One button line: two-flop synchroniser, debounce counter, registered
// press/release edge pulses and, when GAMEPAD_AUTOREPEAT_EN is defined,
// an auto-repeat generator that re-pulses press while the button is held.
module gamepad_channel #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef GAMEPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter bit REPEAT_EN     = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_edge
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          sample;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          press_next;

    // Bring the asynchronous pin into the clock domain; idle (released) is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = ~sync_q2;
    assign accept = (sample != level) && (cnt == CNT_LAST);

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sample == level) begin
            cnt <= '0;
        end else if (accept) begin
            level <= sample;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef GAMEPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep;
    logic          repeating;
    logic          rep_fire;

    // A release being accepted this cycle suppresses any repeat pulse.
    assign rep_fire = REPEAT_EN && level && !accept &&
                      (rep == (repeating ? PERIOD_LAST : DELAY_LAST));

    // Count held cycles; first interval is the delay, later ones the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep       <= '0;
            repeating <= 1'b0;
        end else if (!level || accept || !REPEAT_EN) begin
            rep       <= '0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            rep       <= '0;
            repeating <= 1'b1;
        end else begin
            rep <= rep + 1'b1;
        end
    end

    assign press_next = (accept && sample) || rep_fire;
`else
    assign press_next = accept && sample;
`endif

    // Edge pulses are registered alongside the level update so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press        <= 1'b0;
            release_edge <= 1'b0;
        end else begin
            press        <= press_next;
            release_edge <= accept && !sample;
        end
    end

endmodule

// File: rtl/gamepad_conditioner.sv
// Multi-player joystick conditioner: one independent gamepad_channel per
// raw active-low GPIO line (5 per player). Define GAMEPAD_AUTOREPEAT_EN to
// build in auto-repeat for the channels selected by REPEAT_MASK.
module gamepad_conditioner
    import gamepad_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] REPEAT_MASK =
        (BTNS_PER_PLAYER*NUM_PLAYERS)'(default_repeat_mask(NUM_PLAYERS))
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] i_raw,
    output logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] o_level,
    output logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] o_press,
    output logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] o_release
);

    localparam int N = BTNS_PER_PLAYER * NUM_PLAYERS;

    // Reject configurations the counters and default mask cannot represent.
    if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $bits(REPEAT_MASK) != N) begin : g_param_error
        $error("gamepad_conditioner: illegal parameter value");
    end

    // One fully independent conditioner per line.
    for (genvar i = 0; i < N; i++) begin : g_chan
        gamepad_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef GAMEPAD_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_MASK[i])
`endif
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (i_raw[i]),
            .level       (o_level[i]),
            .press       (o_press[i]),
            .release_edge(o_release[i])
        );
    end

endmodule

// File: tb/tb_gamepad_conditioner.sv
// Self-checking bench for gamepad_conditioner with 2 players, 4-cycle
// debounce, repeat delay 10 and period 3. Expected repeat behaviour follows
// whether GAMEPAD_AUTOREPEAT_EN is defined for the build.
module tb_gamepad_conditioner;

    localparam int NP = 2;
    localparam int N  = 5 * NP;
    localparam logic [N-1:0] IDLE = '1;

`ifdef GAMEPAD_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] i_raw;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;

    int checks;
    int errors;

    vec_t vectors [30];

    gamepad_conditioner #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (i_raw),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release)
    );

    // Free-running 100 MHz bench clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one raw pattern and move to just after the next rising edge.
    task automatic applyStimulus(input logic [N-1:0] raw);
        i_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] actual,
                               input logic [N-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b at %0t", name, actual, required, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [N-1:0] lvl,
                            input logic [N-1:0] prs, input logic [N-1:0] rls);
        checkOutput({tag, ".level"},   o_level,   lvl);
        checkOutput({tag, ".press"},   o_press,   prs);
        checkOutput({tag, ".release"}, o_release, rls);
    endtask

    function automatic logic [N-1:0] bitIf(input bit cond, input int idx);
        logic [N-1:0] v;
        v = '0;
        if (cond) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] allIf(input bit cond);
        return cond ? {N{1'b1}} : {N{1'b0}};
    endfunction

    initial begin
        logic [N-1:0] raw;
        bit           exp_p;
        checks = 0;
        errors = 0;

        // Table: channel 0 held for 20 cycles (repeats at 16/19/22/25 when
        // enabled) while channel 4 gets a 3-cycle glitch that must vanish.
        for (int k = 0; k < 30; k++) begin
            int c;
            c = k + 1;
            vectors[k].raw = IDLE;
            if (k < 20) vectors[k].raw[0] = 1'b0;
            if (k < 3)  vectors[k].raw[4] = 1'b0;
            vectors[k].level = bitIf(c >= 6 && c < 26, 0);
            vectors[k].press = bitIf(c == 6 || (REPEAT_ON &&
                                     (c == 16 || c == 19 || c == 22 || c == 25)), 0);
            vectors[k].rel   = bitIf(c == 26, 0);
        end

        // Reset state.
        rst_n = 1'b0;
        i_raw = IDLE;
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset", '0, '0, '0);
        rst_n = 1'b1;
        applyStimulus(IDLE);
        checkAll("idle", '0, '0, '0);

        for (int k = 0; k < 30; k++) begin
            applyStimulus(vectors[k].raw);
            checkAll($sformatf("table[%0d]", k), vectors[k].level, vectors[k].press, vectors[k].rel);
        end
        repeat (5) applyStimulus(IDLE);

        // Player 1 up held 30 cycles, then released.
        for (int t = 1; t <= 45; t++) begin
            raw = IDLE;
            if (t <= 30) raw[5] = 1'b0;
            applyStimulus(raw);
            exp_p = (t == 6) || (REPEAT_ON && t >= 16 && t < 36 && ((t - 16) % 3) == 0);
            checkAll($sformatf("p1up.t%0d", t), bitIf(t >= 6 && t < 36, 5),
                     bitIf(exp_p, 5), bitIf(t == 36, 5));
        end
        repeat (3) applyStimulus(IDLE);

        // Fire is outside the repeat mask: one press only.
        for (int t = 1; t <= 40; t++) begin
            raw = IDLE;
            if (t <= 30) raw[4] = 1'b0;
            applyStimulus(raw);
            checkAll($sformatf("fire.t%0d", t), bitIf(t >= 6 && t < 36, 4),
                     bitIf(t == 6, 4), bitIf(t == 36, 4));
        end
        repeat (3) applyStimulus(IDLE);

        // Every line pressed and released together.
        for (int t = 1; t <= 16; t++) begin
            applyStimulus((t <= 8) ? {N{1'b0}} : IDLE);
            checkAll($sformatf("all.t%0d", t), allIf(t >= 6 && t < 14),
                     allIf(t == 6), allIf(t == 14));
        end
        repeat (3) applyStimulus(IDLE);

        // Reset while channel 1 is held and repeating.
        raw = IDLE;
        raw[1] = 1'b0;
        for (int t = 1; t <= 20; t++) applyStimulus(raw);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rst_async", '0, '0, '0);
        @(posedge clk);
        #1;
        checkAll("rst_hold", '0, '0, '0);
        rst_n = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            applyStimulus(raw);
            checkAll($sformatf("rst_after.t%0d", t), bitIf(t >= 6, 1),
                     bitIf(t == 6, 1), '0);
        end
        // Release lands on what would be the first repeat cycle: release wins.
        for (int t = 1; t <= 8; t++) begin
            applyStimulus(IDLE);
            checkAll($sformatf("rst_rel.t%0d", t), bitIf(t < 6, 1), '0, bitIf(t == 6, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
